// File: rtl/segment_skid_reg_if.sv
// rtl/segment_skid_reg_if.sv - valid/ready stream link carrying a ctrl + data pipeline entry
//
// Signals:
//   valid - entry present (driven by the producer)
//   ready - consumer can take the entry this cycle
//   ctrl  - control payload (write enables, flags, destination register)
//   data  - datapath payload
// Modports:
//   master - producer side (drives valid/ctrl/data, samples ready)
//   slave  - consumer side (samples valid/ctrl/data, drives ready)
interface segment_skid_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );
endinterface

// File: rtl/segment_skid_reg.sv
// rtl/segment_skid_reg.sv - pipeline segment register with 2-entry skid, flush and stall counter
//
// Ports:
//   clk           - pipeline clock; state updates on the falling edge
//   rst           - asynchronous active-high reset
//   flush         - synchronous squash of all held entries (beats accept/release)
//   up            - upstream link (slave): in_valid/in_ready/in_ctrl/in_data
//   dn            - downstream link (master): out_valid/out_ready/out_ctrl/out_data
//   occupancy     - held entries: 0, 1 or 2
//   stall_cnt_clr - synchronous clear of the stall counter
//   stall_cnt     - saturating count of edges with out_valid=1 and out_ready=0
module segment_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    segment_skid_reg_if.slave    up,
    segment_skid_reg_if.master   dn,
    output logic [1:0]           occupancy,
    input  logic                 stall_cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic out_valid;
    logic accept;
    logic release_e;

    // in_ready decodes registered state only, so a downstream stall never
    // ripples combinationally back into the upstream stage.
    assign out_valid = (state_q != EMPTY);
    assign up.ready  = !rst && (state_q != FULL);
    assign accept    = up.valid && up.ready;
    assign release_e = out_valid && dn.ready;

    // Bubbles are zeroed so a squashed slot never carries write enables.
    assign dn.valid  = out_valid;
    assign dn.ctrl   = out_valid ? main_ctrl_q : '0;
    assign dn.data   = out_valid ? main_data_q : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl_q <= up.ctrl;
                        main_data_q <= up.data;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && release_e) begin
                        main_ctrl_q <= up.ctrl;
                        main_data_q <= up.data;
                    end else if (accept) begin
                        skid_ctrl_q <= up.ctrl;
                        skid_data_q <= up.data;
                        state_q     <= FULL;
                    end else if (release_e) begin
                        main_ctrl_q <= '0;
                        main_data_q <= '0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a release can occur.
                    if (release_e) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        skid_ctrl_q <= '0;
                        skid_data_q <= '0;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Flush deliberately leaves the counter alone; only clear/reset zero it.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_segment_skid_reg.sv
// tb/tb_segment_skid_reg.sv - directed self-checking bench for segment_skid_reg
module tb_segment_skid_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       occupancy;
    logic             stall_cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    segment_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    segment_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    segment_skid_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .up           (up_if.slave),
        .dn           (dn_if.master),
        .occupancy    (occupancy),
        .stall_cnt_clr(stall_cnt_clr),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance past the next falling (active) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [63:0] d);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
    endtask

    task automatic clr_cnt();
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        stall_cnt_clr = 1'b0;
        dn_if.ready   = 1'b0;
        drive(1'b0, 16'h0, 64'h0);

        // Reset state
        #2;
        check("rst_out_valid", 64'(dn_if.valid), 64'h0);
        check("rst_in_ready",  64'(up_if.ready), 64'h0);
        check("rst_occupancy", 64'(occupancy),   64'h0);
        check("rst_out_ctrl",  64'(dn_if.ctrl),  64'h0);
        check("rst_stall_cnt", 64'(stall_cnt),   64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(up_if.ready), 64'h1);

        // Streaming, one entry per cycle
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 64'(i * 16));
            tick();
            check("stream_valid", 64'(dn_if.valid), 64'h1);
            check("stream_ctrl",  64'(dn_if.ctrl),  64'(i));
            check("stream_data",  dn_if.data,       64'(i * 16));
            check("stream_occ",   64'(occupancy),   64'h1);
        end
        check("stream_stall", 64'(stall_cnt), 64'h0);

        // Bubbles carry zero payload
        drive(1'b0, 16'hFFFF, 64'hDEAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bubble_valid", 64'(dn_if.valid), 64'h0);
            check("bubble_ctrl",  64'(dn_if.ctrl),  64'h0);
            check("bubble_data",  dn_if.data,       64'h0);
        end

        // Backpressure into the skid entry
        clr_cnt();
        dn_if.ready = 1'b0;
        drive(1'b1, 16'h00A1, 64'hAAAA);
        tick();
        check("bp_a_ctrl",  64'(dn_if.ctrl), 64'h00A1);
        check("bp_a_stall", 64'(stall_cnt),  64'h0);
        drive(1'b1, 16'h00B2, 64'hBBBB);
        tick();
        check("bp_full_occ",   64'(occupancy),   64'h2);
        check("bp_full_rdy",   64'(up_if.ready), 64'h0);
        check("bp_full_ctrl",  64'(dn_if.ctrl),  64'h00A1);
        check("bp_full_stall", 64'(stall_cnt),   64'h1);
        drive(1'b0, 16'h0, 64'h0);
        tick();
        check("bp_hold_stall", 64'(stall_cnt), 64'h2);
        // FULL + out_ready + in_valid: only the release happens
        dn_if.ready = 1'b1;
        drive(1'b1, 16'h00D4, 64'hDDDD);
        tick();
        check("bp_b_ctrl",  64'(dn_if.ctrl),  64'h00B2);
        check("bp_b_data",  dn_if.data,       64'hBBBB);
        check("bp_b_occ",   64'(occupancy),   64'h1);
        check("bp_b_rdy",   64'(up_if.ready), 64'h1);
        check("bp_b_stall", 64'(stall_cnt),   64'h2);
        tick();
        check("bp_d_ctrl", 64'(dn_if.ctrl), 64'h00D4);
        check("bp_d_data", dn_if.data,      64'hDDDD);
        drive(1'b0, 16'h0, 64'h0);
        tick();
        check("bp_drain_valid", 64'(dn_if.valid), 64'h0);

        // Flush while FULL discards held entries and the offered one
        clr_cnt();
        dn_if.ready = 1'b0;
        drive(1'b1, 16'h00E1, 64'hE1);
        tick();
        drive(1'b1, 16'h00E2, 64'hE2);
        tick();
        check("fl_pre_occ", 64'(occupancy), 64'h2);
        flush = 1'b1;
        drive(1'b1, 16'h00C3, 64'hC3);
        tick();
        check("fl_occ",   64'(occupancy),   64'h0);
        check("fl_valid", 64'(dn_if.valid), 64'h0);
        check("fl_ctrl",  64'(dn_if.ctrl),  64'h0);
        check("fl_rdy",   64'(up_if.ready), 64'h1);
        check("fl_stall", 64'(stall_cnt),   64'h2);
        flush = 1'b0;
        drive(1'b0, 16'h0, 64'h0);
        dn_if.ready = 1'b1;
        tick();
        check("fl_after_valid", 64'(dn_if.valid), 64'h0);
        check("fl_after_ctrl",  64'(dn_if.ctrl),  64'h0);

        // Stall counter saturation and clear
        clr_cnt();
        dn_if.ready = 1'b0;
        drive(1'b1, 16'h000F, 64'hF);
        tick();
        drive(1'b0, 16'h0, 64'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", 64'(stall_cnt), 64'd14);
        end
        check("sat_20", 64'(stall_cnt), 64'd15);
        clr_cnt();
        check("sat_clr", 64'(stall_cnt), 64'd0);
        tick();
        check("sat_resume", 64'(stall_cnt), 64'd1);

        // Asynchronous reset between edges
        drive(1'b1, 16'h0066, 64'h66);
        tick();
        drive(1'b0, 16'h0, 64'h0);
        check("ar_pre_occ", 64'(occupancy), 64'h2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(dn_if.valid), 64'h0);
        check("ar_ctrl",  64'(dn_if.ctrl),  64'h0);
        check("ar_data",  dn_if.data,       64'h0);
        check("ar_occ",   64'(occupancy),   64'h0);
        check("ar_rdy",   64'(up_if.ready), 64'h0);
        check("ar_stall", 64'(stall_cnt),   64'h0);
        rst = 1'b0;
        #1;
        check("ar_rdy_after", 64'(up_if.ready), 64'h1);
        dn_if.ready = 1'b1;
        drive(1'b1, 16'h0077, 64'h0123_4567_89AB_CDEF);
        tick();
        check("ar_next_ctrl", 64'(dn_if.ctrl), 64'h0077);
        check("ar_next_data", dn_if.data,      64'h0123_4567_89AB_CDEF);
        drive(1'b0, 16'h0, 64'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/segment_skid_reg.md
Name: segment_skid_reg

Overview:
- Parametrised pipeline segment register with a valid/ready handshake, a 2-entry skid buffer, flush and bubble insertion.
- Used between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of fixed-width segment registers.
- Lets a downstream stage stall without losing in-flight data.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 64, width of the datapath payload (for example ALU result concatenated with write data).
- CTRL_W, 16, width of the control payload (write enables, condition, flags, destination register).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline segments.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  segment can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream datapath payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  control payload; zero when out_valid=0.
- out_data  out  DATA_W  datapath payload; zero when out_valid=0.
- occupancy  out  2  number of held entries (0, 1 or 2).
- stall_cnt_clr  in  1  synchronous clear of the stall counter.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous, rst=1): state EMPTY, main and skid entries zero, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
- in_ready=0 while rst=1. After reset, in_ready = (state != FULL). in_ready is a decode of registered state only; it has no combinational path from out_ready.
- Accept = in_valid & in_ready, sampled at the falling edge.
- Release = out_valid & out_ready, sampled at the falling edge.
- States:
  - EMPTY:
    - accept -> ONE; main loaded from input.
    - otherwise stay EMPTY.
  - ONE (main valid):
    - accept & release -> ONE; main replaced by input.
    - accept only -> FULL; input written to skid.
    - release only -> EMPTY.
    - neither -> hold.
  - FULL (main and skid valid):
    - release -> ONE; main loaded from skid, skid cleared.
    - no release -> hold. No accept is possible because in_ready=0.
- Output mapping:
  - out_valid = (state != EMPTY).
  - out_ctrl and out_data are driven from main. They are forced to zero when not valid, so a bubble carries no write enables.
  - occupancy: EMPTY=0, ONE=1, FULL=2.
- Latency and ordering:
  - An entry accepted into EMPTY appears on out_* right after that falling edge (1 edge of latency).
  - Entries leave in acceptance order, with no drops or duplicates.
  - Throughput is 1 entry per cycle when out_ready=1.
- Flush:
  - Highest priority above accept and release. On a falling edge with flush=1: state becomes EMPTY, main and skid are zeroed, and any simultaneous input is discarded.
  - in_ready keeps following state during flush (it is not forced low). An offered entry is simply not captured.
- Stall counter:
  - On each falling edge with out_valid=1 & out_ready=0, stall_cnt increments and saturates at 2^CNT_W-1.
  - stall_cnt_clr=1 zeroes the counter and takes priority over the increment.
  - flush does not affect the counter.
- Boundaries and corner cases:
  - FULL with out_ready=1 and in_valid=1 on the same edge: only the release happens (in_ready was 0). in_ready rises after that edge.
  - Reset asserted mid-stream: all entries are lost immediately (asynchronous). No partial update survives.
- Widths are exact; no truncation or extension is applied to the payload.

Test Plan:
- Streaming: out_ready=1; feed ctrl=0x0001..0x0005 with data=0x10..0x50 on back-to-back cycles -> each appears on out_* one edge later, in order; occupancy stays at 1; stall_cnt=0.
- Backpressure and skid:
  - Hold out_ready=0 and offer A (ctrl 0x00A1) then B (ctrl 0x00B2) -> occupancy reaches 2, in_ready=0, out shows A.
  - Raise out_ready -> A then B are delivered.
  - stall_cnt equals the number of edges with out_valid=1 and out_ready=0.
- Flush in FULL: two entries held, flush=1 together with in_valid=1 and ctrl 0x00C3 -> next edge occupancy=0, out_valid=0, out_ctrl=0, and 0x00C3 never appears.
- Stall counter saturation: with CNT_W=4, stall for 20 edges -> stall_cnt=15. Pulse stall_cnt_clr for one edge while still stalled -> stall_cnt=0, then resumes counting.
- Asynchronous reset mid-operation: occupancy=2, assert rst between edges -> out_valid, out_ctrl, out_data, occupancy and in_ready go to 0 immediately, without waiting for a clock edge. Deassert rst -> in_ready=1 and the next accepted entry passes correctly.
- Bubble zeroing: no input for 3 cycles while out_ready=1 -> out_ctrl=0x0000 and out_data=0 on every one of those cycles.
